tff_bank_arbiter: RTL and testbench

//  Shares one WIDTH-bit bank of asynchronous-reset T flip-flops between N_REQ requesters.

---
 rtl/tff_arb_pkg.sv | 43 ++++
 rtl/tff_cell.sv | 24 ++
 rtl/tff_bank_arbiter.sv | 95 +++++++++
 tb/tb_tff_bank_arbiter.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/tff_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : tff_arb_pkg
// Brief   : Shared defaults and round-robin pick function for tff_bank_arbiter
// Revision: 1.0
// ============================================================================
package tff_arb_pkg;

    localparam int N_REQ_DEF = 4;
    localparam int WIDTH_DEF = 8;
    localparam int CNT_W_DEF = 16;

    // The pick function works on a fixed-width view so any N_REQ <= MAX_REQ fits.
    localparam int MAX_REQ   = 32;

    typedef logic [4:0] rr_idx_t;

    typedef struct packed {
        logic    valid;
        rr_idx_t idx;
    } rr_pick_t;

    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                         input rr_idx_t            ptr,
                                         input int                 n);
        rr_pick_t r;
        int       c;
        r = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            if (k < n) begin
                c = int'(ptr) + k;
                if (c >= n) c = c - n;
                if (req[c] && !r.valid) begin
                    r.valid = 1'b1;
                    r.idx   = rr_idx_t'(c);
                end
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tff_cell.sv
`default_nettype none
// ============================================================================
// Module  : tff_cell
// Brief   : Single T flip-flop with asynchronous active-high reset
// Revision: 1.0
// ============================================================================
module tff_cell (
    input  logic t,
    input  logic clk,
    input  logic reset,
    output logic q
);

    logic r_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_q <= 1'b0;
        else if (t) r_q <= ~r_q;
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/tff_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tff_bank_arbiter
// Brief   : Round-robin arbiter sharing one bank of T flip-flops among requesters
// Revision: 1.0
// ============================================================================
module tff_bank_arbiter
    import tff_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] mask,
    input  logic                   hold,
    output logic [N_REQ-1:0]       grant,
    output logic [WIDTH-1:0]       q,
    output logic                   busy,
    output logic [CNT_W-1:0]       grant_cnt
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [IDX_W-1:0]   r_ptr;
    logic [N_REQ-1:0]   r_grant;
    logic [CNT_W-1:0]   r_cnt;

    logic [MAX_REQ-1:0] w_req_ext;
    rr_pick_t           w_pick;
    logic               w_valid;
    logic [IDX_W-1:0]   w_win;
    logic [IDX_W-1:0]   w_ptr_next;
    logic [WIDTH-1:0]   w_mask_win;
    logic [N_REQ-1:0]   w_onehot;
    logic [WIDTH-1:0]   w_t;

    always_comb begin
        w_req_ext            = '0;
        w_req_ext[N_REQ-1:0] = req;
    end

    assign w_pick  = rr_pick(w_req_ext, rr_idx_t'(r_ptr), N_REQ);
    assign w_valid = w_pick.valid & ~hold;
    assign w_win   = w_pick.idx[IDX_W-1:0];

    always_comb begin
        w_mask_win = '0;
        w_onehot   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_win == IDX_W'(i)) begin
                w_mask_win  = mask[i*WIDTH +: WIDTH];
                w_onehot[i] = 1'b1;
            end
        end
    end

    assign w_ptr_next = (w_win == IDX_W'(N_REQ - 1)) ? '0 : w_win + IDX_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr   <= '0;
            r_grant <= '0;
            r_cnt   <= '0;
        end else if (w_valid) begin
            r_ptr   <= w_ptr_next;
            r_grant <= w_onehot;
            r_cnt   <= r_cnt + CNT_W'(1);
        end else begin
            r_grant <= '0;
        end
    end

    // Only the winning requester's mask ever reaches the T inputs.
    assign w_t = w_valid ? w_mask_win : '0;

    generate
        for (genvar j = 0; j < WIDTH; j++) begin : g_bank
            tff_cell u_cell (
                .t    (w_t[j]),
                .clk  (clk),
                .reset(reset),
                .q    (q[j])
            );
        end
    endgenerate

    assign grant     = r_grant;
    assign grant_cnt = r_cnt;
    assign busy      = (|req) & ~hold;

endmodule
`default_nettype wire

// File: tb/tb_tff_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_tff_bank_arbiter
// Brief   : Directed self-checking bench for tff_bank_arbiter (4 x 8-bit)
// Revision: 1.0
// ============================================================================
module tb_tff_bank_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] mask;
    logic        hold;
    logic [3:0]  grant;
    logic [7:0]  q;
    logic        busy;
    logic [15:0] grant_cnt;

    int checks   = 0;
    int failures = 0;

    tff_bank_arbiter #(.N_REQ(4), .WIDTH(8), .CNT_W(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .mask     (mask),
        .hold     (hold),
        .grant    (grant),
        .q        (q),
        .busy     (busy),
        .grant_cnt(grant_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        req   = '0;
        mask  = '0;
        hold  = 1'b0;

        // 1: reset state
        tick();
        tick();
        check("rst_q", q, 0);
        check("rst_grant", grant, 0);
        check("rst_cnt", grant_cnt, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;

        // 2: single requester granted every cycle
        req  = 4'b0001;
        mask = 32'h0000_000F;
        tick();
        check("s2_g1", grant, 4'b0001);
        check("s2_q1", q, 8'h0F);
        tick();
        check("s2_g2", grant, 4'b0001);
        check("s2_q2", q, 8'h00);
        check("s2_cnt", grant_cnt, 2);

        // 3: all requesting, round-robin from ptr 0 with wrap
        req = '0;
        do_reset();
        req  = 4'b1111;
        mask = 32'h0804_0201;
        tick(); check("s3_g0", grant, 4'b0001); check("s3_q0", q, 8'h01);
        tick(); check("s3_g1", grant, 4'b0010); check("s3_q1", q, 8'h03);
        tick(); check("s3_g2", grant, 4'b0100); check("s3_q2", q, 8'h07);
        tick(); check("s3_g3", grant, 4'b1000); check("s3_q3", q, 8'h0F);
        tick(); check("s3_g4", grant, 4'b0001); check("s3_q4", q, 8'h0E);
        check("s3_cnt", grant_cnt, 5);

        // 4: hold freezes everything; resume from ptr=1 -> requester 2 wins
        hold = 1'b1;
        req  = 4'b0101;
        #1 check("s4_busy_hold", busy, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("s4_g_hold", grant, 0);
            check("s4_q_hold", q, 8'h0E);
        end
        check("s4_cnt_hold", grant_cnt, 5);
        hold = 1'b0;
        #1 check("s4_busy", busy, 1);
        tick();
        check("s4_g_resume", grant, 4'b0100);
        check("s4_q_resume", q, 8'h0A);
        check("s4_cnt_resume", grant_cnt, 6);

        // 5: async reset between edges in the middle of round-robin
        req = '0;
        do_reset();
        req  = 4'b1111;
        mask = 32'h0804_0201;
        tick(); check("s5_g0", grant, 4'b0001);
        tick(); check("s5_g1", grant, 4'b0010); check("s5_q1", q, 8'h03);
        #2 reset = 1'b1;
        #1;
        check("s5_async_q", q, 0);
        check("s5_async_g", grant, 0);
        check("s5_async_cnt", grant_cnt, 0);
        tick();
        reset = 1'b0;
        tick();
        check("s5_g_after", grant, 4'b0001);
        check("s5_q_after", q, 8'h01);

        // 6: zero mask still granted; counter wraps
        req = '0;
        do_reset();
        req  = 4'b0010;
        mask = 32'h0000_0000;
        for (int k = 0; k < 65535; k++) tick();
        check("s6_cnt_max", grant_cnt, 16'hFFFF);
        tick();
        check("s6_g", grant, 4'b0010);
        check("s6_q", q, 8'h00);
        check("s6_cnt_wrap", grant_cnt, 16'h0000);

        // dropping req stops grants
        req = '0;
        tick();
        check("s6_g_drop", grant, 0);
        check("s6_cnt_drop", grant_cnt, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
